// File: rtl/noc_input_fifo.sv
// noc_input_fifo: per-port router input buffer.
// RTS/CTS one-flit handshake in, FWFT circular buffer out.
module noc_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DRTS,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic                  CTS,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic {
        WAIT   = 1'b0,
        ACCEPT = 1'b1
    } cts_state_t;

    cts_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  write_en;
    logic                  read_en;
    logic                  empty_w;
    logic                  full_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_CNT);

    // Handshake state register (this is the CTS flop).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next handshake state: grant one flit when there is room, then drop.
    always_comb begin
        state_d = WAIT;
        unique case (state_q)
            WAIT:    state_d = (DRTS && !full_w) ? ACCEPT : WAIT;
            ACCEPT:  state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    // Handshake output: CTS is taken straight from the state flop.
    always_comb begin
        CTS = (state_q == ACCEPT);
    end

    assign write_en = DRTS & (state_q == ACCEPT);
    assign read_en  = (read_en_N | read_en_E | read_en_W |
                       read_en_S | read_en_L) & ~empty_w;

    // Next pointers and occupancy; simultaneous push/pop keeps count.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (write_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (read_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (write_en && !read_en) begin
            count_d = count_q + CNT_ONE;
        end else if (read_en && !write_en) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flit storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[wr_ptr_q] <= RX;
        end
    end

    // Registered-only status and head flit (first-word-fall-through).
    always_comb begin
        Data_out = mem_q[rd_ptr_q];
        empty    = empty_w;
        full     = full_w;
        count    = count_q;
    end

endmodule

// File: tb/tb_noc_input_fifo.sv
// tb_noc_input_fifo: directed checks of the router input FIFO.
// Inputs change #1 after posedge; outputs sampled on negedge.
module tb_noc_input_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        DRTS = 1'b0;
    logic [31:0] RX = '0;
    logic [4:0]  rd = '0;
    logic        CTS;
    logic [31:0] Data_out;
    logic        empty;
    logic        full;
    logic [2:0]  count;

    int total = 0;
    int bad = 0;
    int last_n = 0;

    always #5 clk = ~clk;

    noc_input_fifo #(.DATA_WIDTH(32), .DEPTH_LOG2(2)) dut (
        .clk(clk),
        .rst(rst),
        .DRTS(DRTS),
        .RX(RX),
        .read_en_N(rd[4]),
        .read_en_E(rd[3]),
        .read_en_W(rd[2]),
        .read_en_S(rd[1]),
        .read_en_L(rd[0]),
        .CTS(CTS),
        .Data_out(Data_out),
        .empty(empty),
        .full(full),
        .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cts(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!CTS && n < 20);
        chk("cts_seen", {31'b0, CTS}, 1);
    endtask

    // Upstream arbiter model: hold RTS until the CTS pulse.
    task automatic send(input logic [31:0] d, input logic [4:0] rmask);
        int n;
        @(posedge clk); #1;
        DRTS = 1'b1;
        RX = d;
        wait_cts(n);
        last_n = n;
        rd = rmask;
        @(posedge clk); #1;
        DRTS = 1'b0;
        rd = '0;
        @(negedge clk);
        chk("cts_pulse", {31'b0, CTS}, 0);
    endtask

    task automatic pop(input logic [4:0] rmask, input logic [31:0] exp);
        @(posedge clk); #1;
        rd = rmask;
        @(negedge clk);
        chk("pop_data", Data_out, exp);
        @(posedge clk); #1;
        rd = '0;
    endtask

    initial begin
        int n;
        // Reset state
        @(negedge clk);
        chk("rst_cts", {31'b0, CTS}, 0);
        chk("rst_cnt", {29'b0, count}, 0);
        chk("rst_empty", {31'b0, empty}, 1);
        chk("rst_full", {31'b0, full}, 0);
        chk("rst_dout", Data_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single flit: CTS one cycle after DRTS, then readable
        send(32'hA5A5_0001, 5'b0);
        chk("single_lat", last_n, 2);
        chk("single_dout", Data_out, 32'hA5A5_0001);
        chk("single_cnt", {29'b0, count}, 1);
        chk("single_empty", {31'b0, empty}, 0);
        pop(5'b01000, 32'hA5A5_0001);
        @(negedge clk);
        chk("single_drain", {31'b0, empty}, 1);

        // Fill to full, then back-pressure
        for (int i = 1; i <= 4; i++) send(i, 5'b0);
        chk("fill_full", {31'b0, full}, 1);
        chk("fill_cnt", {29'b0, count}, 4);
        @(posedge clk); #1;
        DRTS = 1'b1;
        RX = 32'h5;
        repeat (10) begin
            @(negedge clk);
            chk("bp_cts", {31'b0, CTS}, 0);
        end
        @(posedge clk); #1;
        rd = 5'b01000;
        @(negedge clk);
        chk("bp_head", Data_out, 1);
        @(posedge clk); #1;
        rd = '0;
        wait_cts(n);
        chk("bp_rearm", {31'b0, n <= 2}, 1);
        @(posedge clk); #1;
        DRTS = 1'b0;
        @(negedge clk);
        chk("bp_cnt", {29'b0, count}, 4);
        for (int i = 2; i <= 5; i++) pop(5'b01000, i);
        @(negedge clk);
        chk("bp_empty", {31'b0, empty}, 1);

        // Wrap-around: interleaved writes and reads, in order
        send(32'h1, 5'b0);
        send(32'h2, 5'b0);
        for (int i = 1; i <= 8; i++) begin
            send(i + 2, 5'b0);
            chk("wrap_max", {31'b0, count <= 3'd4}, 1);
            pop(5'b00100, i);
        end
        pop(5'b00100, 32'h9);
        pop(5'b00100, 32'hA);
        @(negedge clk);
        chk("wrap_cnt", {29'b0, count}, 0);

        // Simultaneous read and write at count = 2
        send(32'h11, 5'b0);
        send(32'h22, 5'b0);
        send(32'h33, 5'b00001);
        chk("rw_cnt", {29'b0, count}, 2);
        chk("rw_head", Data_out, 32'h22);
        pop(5'b00001, 32'h22);
        pop(5'b00001, 32'h33);
        @(negedge clk);
        chk("rw_empty", {31'b0, empty}, 1);

        // Read while empty is ignored
        pop(5'b10000, Data_out);
        @(negedge clk);
        chk("ill_cnt", {29'b0, count}, 0);
        chk("ill_empty", {31'b0, empty}, 1);
        send(32'h44, 5'b0);
        chk("ill_head", Data_out, 32'h44);
        send(32'h55, 5'b0);
        send(32'h66, 5'b0);
        chk("multi_pre", {29'b0, count}, 3);
        pop(5'b10010, 32'h44);
        @(negedge clk);
        chk("multi_cnt", {29'b0, count}, 2);
        chk("multi_head", Data_out, 32'h55);
        pop(5'b10000, 32'h55);
        pop(5'b10000, 32'h66);

        // Asynchronous reset mid-stream during a CTS pulse
        send(32'h77, 5'b0);
        send(32'h88, 5'b0);
        @(posedge clk); #1;
        DRTS = 1'b1;
        RX = 32'h99;
        wait_cts(n);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_cts", {31'b0, CTS}, 0);
        chk("arst_cnt", {29'b0, count}, 0);
        chk("arst_empty", {31'b0, empty}, 1);
        chk("arst_dout", Data_out, 0);
        @(posedge clk); #1;
        DRTS = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_cnt", {29'b0, count}, 0);
        chk("post_empty", {31'b0, empty}, 1);
        chk("post_dout", Data_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_input_fifo.md
# noc_input_fifo

Per-port input buffer of the NoC router, the stage directly downstream of an output-port arbiter in the neighbouring router (or NI). It accepts flits with the one-flit RTS/CTS handshake: the upstream arbiter holds RTS until it sees a one-cycle CTS pulse. It stores the flits in a circular buffer and presents the head flit, first-word-fall-through, to the local LBDR and crossbar. The head flit is popped by whichever local output arbiter grants this input.

## Interface
Parameters:
- DATA_WIDTH, 32, flit width in bits.
- DEPTH_LOG2, 2, log2 of buffer depth (DEPTH = 2^DEPTH_LOG2 = 4 by default).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- DRTS  input  1  RTS from the upstream router/NI; high while the flit on RX is valid and not yet accepted.
- RX  input  DATA_WIDTH  incoming flit.
- read_en_N, read_en_E, read_en_W, read_en_S, read_en_L  input  1 each  grants from the local output arbiters; a high value pops the head flit.
- CTS  output  1  registered clear-to-send pulse back to the upstream arbiter (its DCTS).
- Data_out  output  DATA_WIDTH  head flit (mem[rd_ptr]).
- empty  output  1  buffer holds 0 flits.
- full  output  1  buffer holds DEPTH flits.
- count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH x DATA_WIDTH array. rd_ptr and wr_ptr are DEPTH_LOG2 bits each and wrap modulo DEPTH. count is DEPTH_LOG2+1 bits.
- Handshake FSM, held in the single register CTS_FF (CTS = CTS_FF):
  - CTS_FF = 0 (WAIT): go to 1 next cycle if DRTS = 1 and full = 0; otherwise stay at 0.
  - CTS_FF = 1 (ACCEPT): always return to 0 next cycle. CTS is therefore never high for two consecutive cycles.
- Write: write_en = DRTS & CTS_FF. On write_en, RX is stored at mem[wr_ptr] and wr_ptr increments.
- Read: read_en = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) & ~empty. On read_en, rd_ptr increments.
  - More than one read_en_* high in the same cycle still pops exactly one flit.
  - A read while empty is ignored: pointers and count are unchanged.
- count update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged when a write and a read happen in the same cycle; both pointers still advance.
- Overflow cannot occur. CTS is raised only when count < DEPTH, and no other write can occur between the CTS decision and the write cycle. The implementation must not add a separate overflow guard that alters this timing.
- Data_out, empty and full are decoded from registers only. There is no combinational path from any input to any output.

## Timing
- Reset (asynchronous, takes effect immediately), all held while rst = 1:
  - CTS = 0.
  - rd_ptr = wr_ptr = 0, count = 0.
  - empty = 1, full = 0.
  - All memory words cleared, so Data_out = 0.
- Accept sequence:
  - Cycle t: DRTS rises.
  - Cycle t+1: CTS = 1 and the write occurs at the end of this cycle.
  - Cycle t+2: CTS = 0. The upstream arbiter has dropped RTS; the flit is readable, with empty = 0 if the buffer was empty.
- Back-to-back throughput is at most one flit per 3 cycles, fixed by the upstream RTS re-arm. The FIFO must re-raise CTS on the cycle after DRTS re-asserts.
- Read: Data_out shows the head flit in the same cycle a read_en_* is high. The next flit (or a stale word, with empty = 1) appears the following cycle.
- Full: while count = DEPTH, CTS stays 0 regardless of DRTS. CTS can rise the cycle after the first pop.
- Reset during a CTS pulse: CTS clears immediately and no write is committed.

## Test plan
- Reset: assert rst mid-stream with count = 2 and CTS = 1 -> CTS = 0, count = 0, empty = 1, Data_out = 0 asynchronously; on release, no flit is recovered.
- Single flit: DRTS = 1 with RX = 0xA5A5_0001 held until CTS -> CTS high exactly 1 cycle, 1 cycle after DRTS; the next cycle Data_out = 0xA5A5_0001, count = 1, empty = 0.
- Fill and back-pressure: write 4 flits 0x1..0x4 with DEPTH_LOG2 = 2 -> full = 1, count = 4; DRTS held high for 10 cycles gives CTS = 0 throughout; one read_en_E pulse -> CTS = 1 the next cycle, then flit 0x5 is stored.
- Wrap-around: 10 writes interleaved with 10 reads -> flits come out in order 0x1..0xA, pointers wrap twice, count never exceeds 4.
- Simultaneous read and write at count = 2: read_en_L = 1 in the CTS cycle -> count stays 2, head advances, written flit lands at the correct slot.
- Illegal reads: read_en_N = 1 while empty -> no change. read_en_N = read_en_S = 1 with count = 3 -> count = 2, exactly one flit removed.
